// File: rtl/ycc_fp_sequencer.sv
// RGB -> YCbCr converter that time-multiplexes one shared FP32 add/sub/mul unit over 16 steps.
// Defining YCC_PERF_CNT_EN adds the pix_cnt / stall_cnt performance counters.
module ycc_fp_sequencer #(
   parameter int FP_LAT = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [31:0]      R,
   input  logic [31:0]      G,
   input  logic [31:0]      B,
   output logic             ycc_valid,
   input  logic             ycc_ready,
   output logic [31:0]      Y,
   output logic [31:0]      Cb,
   output logic [31:0]      Cr,
   output logic [31:0]      fp_in0,
   output logic [31:0]      fp_in1,
   output logic [1:0]       fp_operand,
   input  logic [31:0]      fp_o,
`ifdef YCC_PERF_CNT_EN
   output logic [CNT_W-1:0] pix_cnt,
   output logic [CNT_W-1:0] stall_cnt,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   localparam int WAIT_W = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(FP_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   localparam logic [1:0]  OP_ADD = 2'd0;
   localparam logic [1:0]  OP_SUB = 2'd1;
   localparam logic [1:0]  OP_MUL = 2'd2;
   localparam logic [31:0] K_Y_R  = 32'h3E991687;
   localparam logic [31:0] K_Y_G  = 32'h3F1645A2;
   localparam logic [31:0] K_Y_B  = 32'h3DE978D5;
   localparam logic [31:0] K_128  = 32'h43000000;
   localparam logic [31:0] K_CB_R = 32'hBE2D0E56;
   localparam logic [31:0] K_CB_G = 32'hBEA978D5;
   localparam logic [31:0] K_HALF = 32'h3F000000;
   localparam logic [31:0] K_CR_G = 32'hBED6872B;
   localparam logic [31:0] K_CR_B = 32'hBDA5E354;

   if (FP_LAT < 1 || CNT_W < 1) begin : g_bad_param
      $error("ycc_fp_sequencer: FP_LAT and CNT_W must be at least 1");
   end

   state_t            state, state_nxt;
   logic [3:0]        step, step_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic [31:0]       r_lat, g_lat, b_lat, r_nxt, g_nxt, b_nxt;
   logic [31:0]       acc, tmp, acc_nxt, tmp_nxt;
   logic [31:0]       y_nxt, cb_nxt, cr_nxt;
   logic [31:0]       in0_nxt, in1_nxt;
   logic [1:0]        op_nxt;
   logic              accept, issue;

   // Next-state, result capture and operand issue; operands read the freshly captured acc/tmp.
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      wait_nxt  = wait_cnt;
      r_nxt     = r_lat;
      g_nxt     = g_lat;
      b_nxt     = b_lat;
      acc_nxt   = acc;
      tmp_nxt   = tmp;
      y_nxt     = Y;
      cb_nxt    = Cb;
      cr_nxt    = Cr;
      in0_nxt   = fp_in0;
      in1_nxt   = fp_in1;
      op_nxt    = fp_operand;
      accept    = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            accept = pix_valid;
         end
         EXEC: begin
            if (wait_cnt == LAST_WAIT) begin
               wait_nxt = {WAIT_W{1'b0}};
               case (step)
                  4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd11, 4'd13: acc_nxt = fp_o;
                  4'd5:    y_nxt   = fp_o;
                  4'd10:   cb_nxt  = fp_o;
                  4'd15:   cr_nxt  = fp_o;
                  default: tmp_nxt = fp_o;
               endcase
               if (step == 4'd15) begin
                  state_nxt = DONE;
               end else begin
                  step_nxt = step + 4'd1;
                  issue    = 1'b1;
               end
            end else begin
               wait_nxt = wait_cnt + WAIT_ONE;
            end
         end
         DONE: begin
            if (ycc_ready) begin
               if (pix_valid) begin
                  accept = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         state_nxt = EXEC;
         step_nxt  = 4'd0;
         wait_nxt  = {WAIT_W{1'b0}};
         r_nxt     = R;
         g_nxt     = G;
         b_nxt     = B;
         issue     = 1'b1;
      end else begin
         r_nxt     = r_lat;
      end
      if (issue) begin
         case (step_nxt)
            4'd0:    begin in0_nxt = r_nxt;   in1_nxt = K_Y_R;   op_nxt = OP_MUL; end
            4'd1:    begin in0_nxt = g_nxt;   in1_nxt = K_Y_G;   op_nxt = OP_MUL; end
            4'd3:    begin in0_nxt = b_nxt;   in1_nxt = K_Y_B;   op_nxt = OP_MUL; end
            4'd5:    begin in0_nxt = acc_nxt; in1_nxt = K_128;   op_nxt = OP_SUB; end
            4'd6:    begin in0_nxt = r_nxt;   in1_nxt = K_CB_R;  op_nxt = OP_MUL; end
            4'd7:    begin in0_nxt = g_nxt;   in1_nxt = K_CB_G;  op_nxt = OP_MUL; end
            4'd9:    begin in0_nxt = b_nxt;   in1_nxt = K_HALF;  op_nxt = OP_MUL; end
            4'd11:   begin in0_nxt = r_nxt;   in1_nxt = K_HALF;  op_nxt = OP_MUL; end
            4'd12:   begin in0_nxt = g_nxt;   in1_nxt = K_CR_G;  op_nxt = OP_MUL; end
            4'd14:   begin in0_nxt = b_nxt;   in1_nxt = K_CR_B;  op_nxt = OP_MUL; end
            default: begin in0_nxt = acc_nxt; in1_nxt = tmp_nxt; op_nxt = OP_ADD; end
         endcase
      end else begin
         op_nxt = fp_operand;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         step       <= 4'd0;
         wait_cnt   <= {WAIT_W{1'b0}};
         r_lat      <= 32'd0;
         g_lat      <= 32'd0;
         b_lat      <= 32'd0;
         acc        <= 32'd0;
         tmp        <= 32'd0;
         Y          <= 32'd0;
         Cb         <= 32'd0;
         Cr         <= 32'd0;
         fp_in0     <= 32'd0;
         fp_in1     <= 32'd0;
         fp_operand <= 2'd0;
         ycc_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         step       <= step_nxt;
         wait_cnt   <= wait_nxt;
         r_lat      <= r_nxt;
         g_lat      <= g_nxt;
         b_lat      <= b_nxt;
         acc        <= acc_nxt;
         tmp        <= tmp_nxt;
         Y          <= y_nxt;
         Cb         <= cb_nxt;
         Cr         <= cr_nxt;
         fp_in0     <= in0_nxt;
         fp_in1     <= in1_nxt;
         fp_operand <= op_nxt;
         ycc_valid  <= (state_nxt == DONE);
         busy       <= (state_nxt == EXEC);
      end
   end

   // In DONE the next pixel may only enter when the current result is taken.
   always_comb begin
      case (state)
         IDLE:    pix_ready = 1'b1;
         DONE:    pix_ready = ycc_ready;
         default: pix_ready = 1'b0;
      endcase
   end

`ifdef YCC_PERF_CNT_EN
   // Handshake and backpressure counters, wrapping at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt   <= {CNT_W{1'b0}};
         stall_cnt <= {CNT_W{1'b0}};
      end else begin
         if (ycc_valid && ycc_ready) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
         end else begin
            pix_cnt <= pix_cnt;
         end
         if (state == DONE && !ycc_ready) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ycc_fp_sequencer.sv
// Directed self-checking bench for ycc_fp_sequencer with a behavioural FP32 unit (FP_LAT=1 and FP_LAT=3).
module tb_ycc_fp_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] F255 = 32'h437F0000;
   localparam logic [31:0] F0   = 32'h00000000;

   logic        rst, pix_valid, pix_ready, ycc_valid, ycc_ready, busy;
   logic [31:0] r_in, g_in, b_in, y, cb, cr, fp_in0, fp_in1, fp_o;
   logic [1:0]  fp_operand;

   logic        rst3, pv3, prdy3, yv3, yrdy3, busy3;
   logic [31:0] r3, g3, b3, y3, cb3, cr3, in0_3, in1_3, fpo3;
   logic [1:0]  op3;
`ifdef YCC_PERF_CNT_EN
   logic [31:0] pix_cnt, stall_cnt, pix_cnt3, stall_cnt3;
`endif

   logic [1:0]  trace [16] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2,
                              2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0};
   logic [31:0] bb_r [4] = '{F255, F255, F0, F0};
   logic [31:0] bb_g [4] = '{F255, F0, F0, F255};
   logic [31:0] bb_b [4] = '{F255, F0, F0, F0};
   real         bb_y [4] = '{127.0, -51.755, -128.0, 21.685};
   real         bb_cb[4] = '{0.0, -43.095, 0.0, -84.405};
   real         bb_cr[4] = '{0.0, 127.5, 0.0, -106.845};

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:23] == 8'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real x);
      logic [63:0] d;
      logic [24:0] m;
      logic [7:0]  e;
      d = $realtobits(x);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      m = {2'b01, d[51:29]};
      if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
      e = 8'(d[62:52] - 11'd896);
      if (m[24]) begin
         e = e + 8'd1;
         m = m >> 1;
      end
      return {d[63], e, m[22:0]};
   endfunction

   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return r2f(f2r(a) + f2r(b));
         2'd1:    return r2f(f2r(a) - f2r(b));
         2'd2:    return r2f(f2r(a) * f2r(b));
         default: return 32'd0;
      endcase
   endfunction

   assign fp_o = fp_model(fp_in0, fp_in1, fp_operand);
   assign fpo3 = fp_model(in0_3, in1_3, op3);

   ycc_fp_sequencer #(.FP_LAT(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .R(r_in), .G(g_in), .B(b_in), .ycc_valid(ycc_valid), .ycc_ready(ycc_ready),
      .Y(y), .Cb(cb), .Cr(cr), .fp_in0(fp_in0), .fp_in1(fp_in1),
      .fp_operand(fp_operand), .fp_o(fp_o),
`ifdef YCC_PERF_CNT_EN
      .pix_cnt(pix_cnt), .stall_cnt(stall_cnt),
`endif
      .busy(busy)
   );

   ycc_fp_sequencer #(.FP_LAT(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst(rst3), .pix_valid(pv3), .pix_ready(prdy3),
      .R(r3), .G(g3), .B(b3), .ycc_valid(yv3), .ycc_ready(yrdy3),
      .Y(y3), .Cb(cb3), .Cr(cr3), .fp_in0(in0_3), .fp_in1(in1_3),
      .fp_operand(op3), .fp_o(fpo3),
`ifdef YCC_PERF_CNT_EN
      .pix_cnt(pix_cnt3), .stall_cnt(stall_cnt3),
`endif
      .busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input logic [31:0] obs, input real exp);
      real v, d;
      v = f2r(obs);
      d = v - exp;
      if (d < 0.0) d = -d;
      checks++;
      assert (d < 1.0e-3) else begin
         errors++;
         $error("FAIL %s: got %f (0x%08h), want %f", tag, v, obs, exp);
      end
   endtask

   // Offers one pixel to the FP_LAT=1 instance from IDLE and checks latency, results and optionally the op trace.
   task automatic run_pix(input string tag, input logic [31:0] rv, input logic [31:0] gv, input logic [31:0] bv,
                          input real ey, input real ecb, input real ecr, input bit do_trace);
      int n;
      @(negedge clk);
      pix_valid = 1'b1;
      r_in = rv;
      g_in = gv;
      b_in = bv;
      @(negedge clk);
      pix_valid = 1'b0;
      n = 0;
      while (!ycc_valid && n < 100) begin
         if (do_trace && n < 16) chk({tag, "_op"}, 32'(fp_operand), 32'(trace[n]));
         if (do_trace && n == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
         n++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, n, 32'd16);
      chk_near({tag, "_y"}, y, ey);
      chk_near({tag, "_cb"}, cb, ecb);
      chk_near({tag, "_cr"}, cr, ecr);
   endtask

   initial begin
      int n, nacc, nres, last, idle_cnt, rdy_cnt, bad;
      bit hs;
      logic [31:0] hold_y, hold_cb, hold_cr;

      rst = 1'b1; rst3 = 1'b1;
      pix_valid = 1'b0; ycc_ready = 1'b1; r_in = F0; g_in = F0; b_in = F0;
      pv3 = 1'b0; yrdy3 = 1'b1; r3 = F0; g3 = F0; b3 = F0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(ycc_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_y", y, 32'd0);
      chk("rst_cb", cb, 32'd0);
      chk("rst_cr", cr, 32'd0);
      chk("rst_in0", fp_in0, 32'd0);
      chk("rst_in1", fp_in1, 32'd0);
      chk("rst_op", 32'(fp_operand), 32'd0);
      rst = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(pix_ready), 32'd1);

      run_pix("gray", F255, F255, F255, 127.0, 0.0, 0.0, 1'b1);
      chk("done_ready", 32'(pix_ready), 32'd1);
      run_pix("red", F255, F0, F0, -51.755, -43.095, 127.5, 1'b0);
      run_pix("zero", F0, F0, F0, -128.0, 0.0, 0.0, 1'b0);
      chk("zero_y_bits", y, 32'hC3000000);
      chk("zero_cb_bits", cb & 32'h7FFFFFFF, 32'd0);
      chk("zero_cr_bits", cr & 32'h7FFFFFFF, 32'd0);

      // Back-to-back: DONE takes the next pixel on its handshake cycle, so results are 17 negedges apart.
      @(negedge clk);
      pix_valid = 1'b1;
      r_in = bb_r[0]; g_in = bb_g[0]; b_in = bb_b[0];
      nacc = 0; nres = 0; last = 0; idle_cnt = 0; rdy_cnt = 0;
      for (int c = 0; c < 200 && nres < 4; c++) begin
         if (ycc_valid) begin
            chk_near("b2b_y", y, bb_y[nres]);
            chk_near("b2b_cb", cb, bb_cb[nres]);
            chk_near("b2b_cr", cr, bb_cr[nres]);
            if (nres > 0) chk("b2b_gap", c - last, 32'd17);
            last = c;
            nres++;
         end else if (c > 0 && !busy) begin
            idle_cnt++;
         end
         hs = pix_ready && pix_valid;
         if (nacc < 4 && pix_ready) rdy_cnt++;
         @(negedge clk);
         if (hs) begin
            nacc++;
            if (nacc < 4) begin
               r_in = bb_r[nacc]; g_in = bb_g[nacc]; b_in = bb_b[nacc];
            end else begin
               pix_valid = 1'b0;
            end
         end
      end
      chk("b2b_results", nres, 32'd4);
      chk("b2b_idle_cycles", idle_cnt, 32'd0);
      chk("b2b_ready_cycles", rdy_cnt, 32'd4);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ycc_ready = 1'b0;
      pix_valid = 1'b1;
      r_in = F255; g_in = F0; b_in = F0;
      @(negedge clk);
      pix_valid = 1'b0;
      n = 0;
      while (!ycc_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("bp_latency", n, 32'd16);
      hold_y = y; hold_cb = cb; hold_cr = cr;
      pix_valid = 1'b1;
      r_in = F0;
      bad = 0;
      for (int s = 0; s < 10; s++) begin
         if (!ycc_valid || pix_ready || busy || y !== hold_y || cb !== hold_cb || cr !== hold_cr) bad++;
         @(negedge clk);
      end
      chk("bp_stable", bad, 32'd0);
      chk("bp_valid_held", 32'(ycc_valid), 32'd1);
      chk_near("bp_y", y, -51.755);
      ycc_ready = 1'b1;
      pix_valid = 1'b0;
      @(negedge clk);
      chk("bp_released", 32'(ycc_valid), 32'd0);
      chk("bp_no_accept", 32'(busy), 32'd0);
`ifdef YCC_PERF_CNT_EN
      chk("bp_stall_cnt", stall_cnt, 32'd10);
      chk("bp_pix_cnt", pix_cnt, 32'd1);
`endif

      @(negedge clk);
      pix_valid = 1'b1;
      r_in = F255; g_in = F255; b_in = F255;
      @(negedge clk);
      pix_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_op", 32'(fp_operand), 32'd2);
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_y", y, 32'd0);
      chk("mid_rst_cb", cb, 32'd0);
      chk("mid_rst_in0", fp_in0, 32'd0);
      chk("mid_rst_in1", fp_in1, 32'd0);
      chk("mid_rst_op", 32'(fp_operand), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(ycc_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_pix("post_rst", F255, F0, F0, -51.755, -43.095, 127.5, 1'b0);

      @(negedge clk);
      pv3 = 1'b1;
      r3 = F255; g3 = F255; b3 = F255;
      @(negedge clk);
      pv3 = 1'b0;
      repeat (22) @(negedge clk);
      chk("lat3_mid_op", 32'(op3), 32'd2);
      chk("lat3_mid_busy", 32'(busy3), 32'd1);
      chk_near("lat3_mid_y", y3, 127.0);
      rst3 = 1'b1;
      #1;
      chk("lat3_rst_y", y3, 32'd0);
      chk("lat3_rst_in0", in0_3, 32'd0);
      chk("lat3_rst_op", 32'(op3), 32'd0);
      chk("lat3_rst_busy", 32'(busy3), 32'd0);
      chk("lat3_rst_valid", 32'(yv3), 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      @(negedge clk);
      pv3 = 1'b1;
      r3 = F255; g3 = F0; b3 = F0;
      @(negedge clk);
      pv3 = 1'b0;
      n = 0;
      while (!yv3 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("lat3_latency", n, 32'd48);
      chk_near("lat3_y", y3, -51.755);
      chk_near("lat3_cb", cb3, -43.095);
      chk_near("lat3_cr", cr3, 127.5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
